// File: rtl/snn_pkg.sv
// snn_pkg: shared state encoding and default widths for the spiking-layer scheduler
//   state_t : FSM encoding IDLE..EMIT
//   STEP_W  : step index width for the default NUM_STEPS
//   SET_W   : settle counter width for the default SETTLE_CYCLES
package snn_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, WAIT_IN, STEP, SETTLE, EMIT} state_t;
   localparam int NUM_STEPS = 16;
   localparam int SETTLE_CYCLES = 1;
   localparam int STEP_W = $clog2(NUM_STEPS + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
endpackage

// File: rtl/hidden_layer_step_scheduler.sv
// hidden_layer_step_scheduler: runs one hidden layer through NUM_STEPS timesteps per sample
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : begin a sample (IDLE only) / drop the current sample
//   in_valid/in_ready/in_spk        : per-timestep fan-in handshake
//   fan_in, rec_spk     : latched input and previous-step layer spikes fed to the layer
//   layer_reset, layer_step, layer_spk : neuron clear, update enable, neuron spikes
//   out_valid/out_ready/out_spk/out_last : per-step output handshake
//   step_idx, busy, done : progress, activity, end-of-sample pulse
module hidden_layer_step_scheduler
   import snn_pkg::*;
#(
   parameter int NUM_FAN_IN = 8,
   parameter int NUM_HIDDEN = 64,
   parameter int NUM_STEPS = 16,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               abort,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [NUM_FAN_IN-1:0]              in_spk,
   output logic [NUM_FAN_IN-1:0]              fan_in,
   output logic [NUM_HIDDEN-1:0]              rec_spk,
   output logic                               layer_reset,
   output logic                               layer_step,
   input  logic [NUM_HIDDEN-1:0]              layer_spk,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [NUM_HIDDEN-1:0]              out_spk,
   output logic                               out_last,
   output logic [$clog2(NUM_STEPS+1)-1:0]     step_idx,
   output logic                               busy,
   output logic                               done
);
   localparam int SW = $clog2(NUM_STEPS + 1);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SW-1:0] LAST = SW'(NUM_STEPS - 1);
   localparam logic [CW-1:0] CNT0 = CW'(SETTLE_CYCLES - 1);
   state_t state, nxt;
   logic [CW-1:0] cnt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? CLEAR : IDLE;
         CLEAR:   nxt = WAIT_IN;
         WAIT_IN: nxt = in_valid ? STEP : WAIT_IN;
         STEP:    nxt = SETTLE;
         SETTLE:  nxt = (cnt == '0) ? EMIT : SETTLE;
         EMIT:    nxt = out_ready ? (out_last ? IDLE : WAIT_IN) : EMIT;
         default: nxt = IDLE;
      endcase
      if (abort) nxt = IDLE;
   end
   // Handshake/strobe outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         in_ready    <= 1'b0;
         layer_step  <= 1'b0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         layer_reset <= 1'b1;
         out_last    <= 1'b0;
         fan_in      <= '0;
         rec_spk     <= '0;
         out_spk     <= '0;
         step_idx    <= '0;
      end else begin
         state       <= nxt;
         in_ready    <= nxt == WAIT_IN;
         layer_step  <= nxt == STEP;
         out_valid   <= nxt == EMIT;
         busy        <= nxt != IDLE;
         layer_reset <= abort || nxt == CLEAR;
         done        <= !abort && state == EMIT && out_ready && out_last;
         cnt         <= state == STEP ? CNT0 : state == SETTLE ? cnt - 1'b1 : cnt;
         if (!abort && state == WAIT_IN && in_valid) fan_in <= in_spk;
         if (abort) begin
            step_idx <= '0;
            rec_spk  <= '0;
            out_last <= 1'b0;
         end else if (state == CLEAR) begin
            step_idx <= '0;
            rec_spk  <= '0;
         end else if (state == SETTLE && cnt == '0) begin
            out_spk  <= layer_spk;
            rec_spk  <= layer_spk;
            out_last <= step_idx == LAST;
         end else if (state == EMIT && out_ready) begin
            step_idx <= out_last ? '0 : step_idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_hidden_layer_step_scheduler.sv
// tb_hidden_layer_step_scheduler: self-checking bench with a sample-level scoreboard and a behavioural layer
module tb_hidden_layer_step_scheduler;
   localparam int NS_A = 4;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;

   logic start = 0, abort = 0, in_valid = 0, out_ready = 0;
   logic in_ready, layer_reset, layer_step, out_valid, out_last, busy, done;
   logic [7:0] in_spk = 0, fan_in;
   logic [63:0] rec_spk, out_spk, layer_spk = 0;
   logic [2:0] step_idx;

   logic b_start = 0, b_abort = 0, b_in_valid = 0, b_out_ready = 0;
   logic b_in_ready, b_layer_reset, b_layer_step, b_out_valid, b_out_last, b_busy, b_done;
   logic [7:0] b_fan_in;
   logic [63:0] b_rec_spk, b_out_spk, b_layer_spk = 0;
   logic [0:0] b_step_idx;

   hidden_layer_step_scheduler #(.NUM_FAN_IN(8), .NUM_HIDDEN(64), .NUM_STEPS(NS_A), .SETTLE_CYCLES(1)) u_a (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
      .in_spk(in_spk), .fan_in(fan_in), .rec_spk(rec_spk), .layer_reset(layer_reset), .layer_step(layer_step),
      .layer_spk(layer_spk), .out_valid(out_valid), .out_ready(out_ready), .out_spk(out_spk), .out_last(out_last),
      .step_idx(step_idx), .busy(busy), .done(done));

   hidden_layer_step_scheduler #(.NUM_FAN_IN(8), .NUM_HIDDEN(64), .NUM_STEPS(1), .SETTLE_CYCLES(3)) u_b (
      .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_spk(8'h5A), .fan_in(b_fan_in), .rec_spk(b_rec_spk), .layer_reset(b_layer_reset), .layer_step(b_layer_step),
      .layer_spk(b_layer_spk), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_spk(b_out_spk), .out_last(b_out_last),
      .step_idx(b_step_idx), .busy(b_busy), .done(b_done));

   int passes = 0, checks = 0;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs === exp) passes++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Behavioural neuron layer: spikes are a fixed mix of the fan-in and the recurrent vector.
   function automatic logic [63:0] lf(input logic [7:0] i, input logic [63:0] r);
      return {8{i}} ^ {r[62:0], r[63]} ^ 64'hA5A5_0123_4567_89AB;
   endfunction
   always @(posedge clk) if (layer_step) layer_spk <= lf(fan_in, rec_spk);
   always @(posedge clk) if (b_layer_step) b_layer_spk <= {$urandom, $urandom};

   // Sample-level scoreboard: accepted inputs in order, one output beat per input.
   logic [7:0] q[$];
   logic [63:0] exp_rec = 0, exp_out = 0;
   int beat = 0;
   bit done_due = 0;
   always @(negedge clk) begin
      if (!reset) begin
         if (layer_reset) begin
            q.delete();
            exp_rec = 0;
            beat = 0;
            done_due = 0;
         end else begin
            check("done", done, done_due);
            done_due = 0;
            check("io_exclusive", in_ready & out_valid, 0);
            if (layer_step) begin
               if (q.size() == 0) check("step_without_accept", 1, 0);
               else begin
                  check("fan_in", fan_in, q[0]);
                  check("rec_spk", rec_spk, exp_rec);
                  exp_out = lf(q.pop_front(), exp_rec);
               end
            end
            if (out_valid && out_ready && !abort) begin
               check("out_spk", out_spk, exp_out);
               check("out_last", out_last, beat == NS_A - 1);
               check("step_idx", step_idx, beat);
               exp_rec = exp_out;
               if (beat == NS_A - 1) begin
                  beat = 0;
                  done_due = 1;
               end else beat++;
            end
            if (in_valid && in_ready && !abort) q.push_back(in_spk);
         end
      end
   end

   bit iv_rnd = 0, or_rnd = 0;
   logic iv_val = 1, or_val = 1;
   task automatic tick;
      @(posedge clk);
      #1;
      start = 0;
      abort = 0;
      in_spk = 8'($urandom);
      in_valid = iv_rnd ? 1'($urandom) : iv_val;
      out_ready = or_rnd ? 1'($urandom) : or_val;
   endtask

   task automatic run_sample(input string tag);
      bit seen = 0;
      tick;
      start = 1;
      for (int k = 0; k < 600 && !seen; k++) begin
         tick;
         @(negedge clk);
         seen = done;
      end
      if (!seen) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_a(input string tag, input int which);
      bit seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         seen = which == 0 ? out_valid : which == 1 ? in_ready : (layer_step && step_idx == 2);
         if (!seen) tick;
      end
      if (!seen) check({tag, "_timeout"}, 0, 1);
   endtask

   logic [63:0] so;
   logic sl;
   logic [2:0] si;
   int n;
   initial begin
      repeat (3) tick;
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_layer_step", layer_step, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_fan_in", fan_in, 0);
      check("rst_rec_spk", rec_spk, 0);
      check("rst_out_spk", out_spk, 0);
      check("rst_step_idx", step_idx, 0);
      check("rst_layer_reset", layer_reset, 1);
      check("rst_b_layer_reset", b_layer_reset, 1);
      reset = 0;
      tick;
      run_sample("full_rate");

      iv_val = 0;
      tick;
      start = 1;
      wait_a("wait_in", 1);
      si = step_idx;
      repeat (5) begin
         tick;
         @(negedge clk);
         check("withheld_step", layer_step, 0);
         check("withheld_idx", step_idx, si);
         check("withheld_ready", in_ready, 1);
      end
      tick;
      in_valid = 1;
      in_spk = 8'h3C;
      tick;
      @(negedge clk);
      check("accept_fan_in", fan_in, 8'h3C);
      check("accept_step", layer_step, 1);
      iv_val = 1;
      for (int k = 0; k < 100 && busy; k++) tick;

      tick;
      start = 1;
      wait_a("step2", 2);
      tick;
      abort = 1;
      tick;
      @(negedge clk);
      check("abort_layer_reset", layer_reset, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_step_idx", step_idx, 0);
      check("abort_busy", busy, 0);
      check("abort_rec_spk", rec_spk, 0);
      tick;
      @(negedge clk);
      check("abort_no_done", done, 0);

      b_in_valid = 1;
      b_start = 1;
      @(posedge clk);
      #1 b_start = 0;
      n = 0;
      while (!b_layer_step && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("b_step_seen", b_layer_step, 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!b_out_valid && n < 20);
      check("b_latency", n, 4);
      check("b_out_last", b_out_last, 1);
      check("b_out_spk", b_out_spk, b_layer_spk);
      @(posedge clk);
      #1 b_out_ready = 1;
      @(negedge clk);
      @(negedge clk);
      check("b_done", b_done, 1);
      check("b_out_valid_clr", b_out_valid, 0);
      b_out_ready = 0;
      b_in_valid = 0;

      iv_rnd = 1;
      or_rnd = 1;
      repeat (6) run_sample("random");
      iv_rnd = 0;
      or_rnd = 0;

      or_val = 0;
      tick;
      start = 1;
      wait_a("emit", 0);
      so = out_spk;
      sl = out_last;
      si = step_idx;
      for (int k = 0; k < 10; k++) begin
         tick;
         if (k == 4) start = 1;
         @(negedge clk);
         check("stall_out_spk", out_spk, so);
         check("stall_out_last", out_last, sl);
         check("stall_valid", out_valid, 1);
         check("stall_in_ready", in_ready, 0);
         check("stall_step", layer_step, 0);
         check("stall_layer_reset", layer_reset, 0);
      end
      or_val = 1;
      tick;
      or_val = 0;
      tick;
      @(negedge clk);
      check("post_stall_idx", step_idx, si + 3'd1);
      check("post_stall_busy", busy, 1);
      repeat (3) tick;
      reset = 1;
      tick;
      @(negedge clk);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_step", layer_step, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_last", out_last, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_fan_in", fan_in, 0);
      check("mid_rst_rec_spk", rec_spk, 0);
      check("mid_rst_out_spk", out_spk, 0);
      check("mid_rst_step_idx", step_idx, 0);
      check("mid_rst_layer_reset", layer_reset, 1);
      reset = 0;
      or_val = 1;
      tick;
      run_sample("after_reset");
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
